// File: rtl/i2c_seq_pkg.sv
// ---------------------------------------------------------------------------
// i2c_seq_pkg
// Shared definitions for the I2C init sequencer: the controller state
// encoding, the command-table entry layout {dev[6:0], reg[7:0], data[7:0]},
// the two reserved device codes, and helpers that pull fields out of an entry.
// ---------------------------------------------------------------------------
package i2c_seq_pkg;

    localparam int ENTRY_W = 23;

    // Field slices inside a table entry
    localparam int DEV_MSB  = 22;
    localparam int DEV_LSB  = 16;
    localparam int REG_MSB  = 15;
    localparam int REG_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    // Reserved device codes: end of table, and "wait data*DELAY_UNIT cycles"
    localparam logic [6:0] DEV_END   = 7'h00;
    localparam logic [6:0] DEV_DELAY = 7'h7F;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DELAY     = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERROR     = 3'd7
    } seq_state_t;

    function automatic logic [6:0] entry_dev(input logic [ENTRY_W-1:0] e);
        return e[DEV_MSB:DEV_LSB];
    endfunction

    function automatic logic [7:0] entry_reg(input logic [ENTRY_W-1:0] e);
        return e[REG_MSB:REG_LSB];
    endfunction

    function automatic logic [7:0] entry_data(input logic [ENTRY_W-1:0] e);
        return e[DATA_MSB:DATA_LSB];
    endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// ---------------------------------------------------------------------------
// i2c_init_rom
// Command table with a registered read (1-cycle latency).
// Ports:
//   clk_in   - clock
//   reset_in - asynchronous active-low reset (clears the read register)
//   addr     - table index to read
//   entry    - {dev, reg, data} of the entry addressed on the previous edge
// Unlisted addresses read as the end marker.
// ---------------------------------------------------------------------------
module i2c_init_rom
    import i2c_seq_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic [ADDR_W-1:0]  addr,
    output logic [ENTRY_W-1:0] entry
);

    logic [ENTRY_W-1:0] table_word;

    always_comb begin
        table_word = {DEV_END, 8'h00, 8'h00};
        case (32'(addr))
            32'd0:   table_word = {7'h3C, 8'h00, 8'hAE};  // display off
            32'd1:   table_word = {7'h3C, 8'h00, 8'hAF};  // display on
            32'd2:   table_word = {7'h3C, 8'h81, 8'h7F};  // contrast
            32'd3:   table_word = {7'h50, 8'h10, 8'hA5};  // second device
            32'd4:   table_word = {DEV_DELAY, 8'h33, 8'h00};  // zero delay, skipped
            32'd5:   table_word = {DEV_DELAY, 8'h5A, 8'h03};  // 3 delay ticks
            32'd6:   table_word = {7'h3C, 8'h20, 8'h02};  // addressing mode
            default: table_word = {DEV_END, 8'h00, 8'h00};
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            entry <= '0;
        end else begin
            entry <= table_word;
        end
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_init_sequencer
// Walks the init command table and hands each write to an I2C controller.
// Ports:
//   clk_in        - single clock
//   reset_in      - asynchronous active-low reset
//   go_in         - rising edge starts a sequence (ignored while busy)
//   ready_in      - controller ready (same clock domain, sampled directly)
//   start_out     - start request; high while waiting for the controller to
//                   take the command (ready_in dropping)
//   dev_addr_out, reg_addr_out, data_out - current write command
//   cmd_idx_out   - current table index
//   busy_out      - sequence running
//   done_out      - sequence completed (held until the next go)
//   error_out     - controller timed out (held until the next go)
//   state_out     - current controller state, for debug
// Handshake: ISSUE waits for ready_in=1, then start_out rises (WAIT_ACK);
// start_out stays high until ready_in=0 is sampled; completion is the next
// ready_in=1. All three phases share one timeout budget per command.
// ---------------------------------------------------------------------------
module i2c_init_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int NUM_CMDS       = 16,
    parameter int DELAY_UNIT     = 50000,
    parameter int TIMEOUT_CYCLES = 5000000,
    localparam int IDX_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1,
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             go_in,
    input  logic             ready_in,
    output logic             start_out,
    output logic [6:0]       dev_addr_out,
    output logic [7:0]       reg_addr_out,
    output logic [7:0]       data_out,
    output logic [IDX_W-1:0] cmd_idx_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             error_out,
    output seq_state_t       state_out
);

    localparam logic [23:0] DELAY_UNIT_24 = 24'(DELAY_UNIT);

    seq_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ENTRY_W-1:0] rom_entry;
    logic               go_q, go_rise;
    logic [TMO_W-1:0]   tmo_q;
    logic [23:0]        dly_q;
    logic               tmo_hit;
    logic               last_idx;
    seq_state_t         adv_state;
    logic [IDX_W-1:0]   adv_idx;

    // The ROM is addressed with the next index so the entry is already
    // valid during the single FETCH cycle.
    i2c_init_rom #(.ADDR_W(IDX_W)) u_rom (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .addr     (idx_d),
        .entry    (rom_entry)
    );

    assign go_rise  = go_in & ~go_q;
    assign tmo_hit  = (tmo_q >= TMO_W'(TIMEOUT_CYCLES - 1));
    assign last_idx = (idx_q == IDX_W'(NUM_CMDS - 1));

    // Where "advance to the next entry" lands: no wrap past the last index.
    always_comb begin
        adv_state = last_idx ? ST_DONE : ST_FETCH;
        adv_idx   = last_idx ? idx_q : idx_q + IDX_W'(1);
    end

    // State register
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (go_rise) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                end
            end
            ST_FETCH: begin
                if (entry_dev(rom_entry) == DEV_END) begin
                    state_d = ST_DONE;
                end else if (entry_dev(rom_entry) == DEV_DELAY) begin
                    if (entry_data(rom_entry) == 8'h00) begin
                        state_d = adv_state;
                        idx_d   = adv_idx;
                    end else begin
                        state_d = ST_DELAY;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ready_in)     state_d = ST_WAIT_ACK;
                else if (tmo_hit) state_d = ST_ERROR;
            end
            ST_WAIT_ACK: begin
                if (!ready_in)    state_d = ST_WAIT_DONE;
                else if (tmo_hit) state_d = ST_ERROR;
            end
            ST_WAIT_DONE: begin
                if (ready_in) begin
                    state_d = adv_state;
                    idx_d   = adv_idx;
                end else if (tmo_hit) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DELAY: begin
                if (dly_q <= 24'd1) begin
                    state_d = adv_state;
                    idx_d   = adv_idx;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: index, go edge register, counters and the latched command
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            go_q         <= 1'b0;
            idx_q        <= '0;
            tmo_q        <= '0;
            dly_q        <= '0;
            dev_addr_out <= '0;
            reg_addr_out <= '0;
            data_out     <= '0;
        end else begin
            go_q  <= go_in;
            idx_q <= idx_d;

            if (state_q == ST_FETCH && state_d == ST_ISSUE) begin
                dev_addr_out <= entry_dev(rom_entry);
                reg_addr_out <= entry_reg(rom_entry);
                data_out     <= entry_data(rom_entry);
                tmo_q        <= '0;
            end else if (state_q inside {ST_ISSUE, ST_WAIT_ACK, ST_WAIT_DONE}) begin
                // Saturate so a progress step taken on the last budget cycle
                // cannot wrap the count back below the limit.
                if (tmo_q != '1) tmo_q <= tmo_q + TMO_W'(1);
            end

            if (state_q == ST_FETCH && state_d == ST_DELAY) begin
                dly_q <= 24'(entry_data(rom_entry)) * DELAY_UNIT_24;
            end else if (state_q == ST_DELAY) begin
                dly_q <= dly_q - 24'd1;
            end
        end
    end

    // Outputs decoded from state; start_out falls with the async reset.
    always_comb begin
        start_out   = (state_q == ST_WAIT_ACK);
        busy_out    = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
        done_out    = (state_q == ST_DONE);
        error_out   = (state_q == ST_ERROR);
        cmd_idx_out = idx_q;
        state_out   = state_q;
    end

endmodule
